// File: rtl/counter_nest_if.sv
// Control and index bus between the layer controller (master) and counter_nest (slave).
// The X stride signal exists only when COUNTER_NEST_STRIDE_EN is defined.
interface counter_nest_if #(
  parameter int WIDTH_X = 8,
  parameter int WIDTH_Y = 8,
  parameter int WIDTH_C = 4
`ifdef COUNTER_NEST_STRIDE_EN
  , parameter int STRIDE_W = 3
`endif
);
  logic               COUNTERN_Start;
  logic               COUNTERN_En;
  logic [WIDTH_X-1:0] COUNTERN_LimX;
  logic [WIDTH_Y-1:0] COUNTERN_LimY;
  logic [WIDTH_C-1:0] COUNTERN_LimC;
`ifdef COUNTER_NEST_STRIDE_EN
  logic [STRIDE_W-1:0] COUNTERN_StrideX;
`endif
  logic [WIDTH_X-1:0] COUNTERN_OutX;
  logic [WIDTH_Y-1:0] COUNTERN_OutY;
  logic [WIDTH_C-1:0] COUNTERN_OutC;
  logic               COUNTERN_Busy;
  logic               COUNTERN_Last;
  logic               COUNTERN_WrapX;
  logic               COUNTERN_WrapY;
  logic               COUNTERN_Done;

  modport master (
`ifdef COUNTER_NEST_STRIDE_EN
    output COUNTERN_StrideX,
`endif
    output COUNTERN_Start, COUNTERN_En,
    output COUNTERN_LimX, COUNTERN_LimY, COUNTERN_LimC,
    input  COUNTERN_OutX, COUNTERN_OutY, COUNTERN_OutC,
    input  COUNTERN_Busy, COUNTERN_Last, COUNTERN_WrapX, COUNTERN_WrapY, COUNTERN_Done
  );

  modport slave (
`ifdef COUNTER_NEST_STRIDE_EN
    input  COUNTERN_StrideX,
`endif
    input  COUNTERN_Start, COUNTERN_En,
    input  COUNTERN_LimX, COUNTERN_LimY, COUNTERN_LimC,
    output COUNTERN_OutX, COUNTERN_OutY, COUNTERN_OutC,
    output COUNTERN_Busy, COUNTERN_Last, COUNTERN_WrapX, COUNTERN_WrapY, COUNTERN_Done
  );
endinterface

// File: rtl/counter_nest.sv
// Three-level X/Y/C nested sweep counter with run-time limits latched on Start.
// Define COUNTER_NEST_STRIDE_EN to add a latched X stride; otherwise X steps by 1.
module counter_nest #(
  parameter int WIDTH_X  = 8,
  parameter int WIDTH_Y  = 8,
  parameter int WIDTH_C  = 4,
  parameter int STRIDE_W = 3
) (
  input  logic           COUNTERN_Clk,
  input  logic           COUNTERN_Clr,
  counter_nest_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [WIDTH_X-1:0] x_q, lim_x_q;
  logic [WIDTH_Y-1:0] y_q, lim_y_q;
  logic [WIDTH_C-1:0] c_q, lim_c_q;
  logic               done_q;

  logic [STRIDE_W-1:0] step;
  logic [WIDTH_X:0]    step_ext;
  logic                busy, x_at_end, y_at_end, c_at_end;

`ifdef COUNTER_NEST_STRIDE_EN
  logic [STRIDE_W-1:0] stride_q;
  assign step = (stride_q == '0) ? STRIDE_W'(1) : stride_q;
`else
  assign step = STRIDE_W'(1);
`endif

  // End-of-row test is one bit wider than X so x+step can never wrap past the limit.
  assign step_ext = (WIDTH_X+1)'(step);
  assign x_at_end = ({1'b0, x_q} + step_ext) > {1'b0, lim_x_q};
  assign y_at_end = (y_q == lim_y_q);
  assign c_at_end = (c_q == lim_c_q);
  assign busy     = (state == RUN);

  assign bus.COUNTERN_OutX  = x_q;
  assign bus.COUNTERN_OutY  = y_q;
  assign bus.COUNTERN_OutC  = c_q;
  assign bus.COUNTERN_Busy  = busy;
  assign bus.COUNTERN_Done  = done_q;
  assign bus.COUNTERN_Last  = busy & x_at_end & y_at_end & c_at_end;
  assign bus.COUNTERN_WrapX = busy & bus.COUNTERN_En & x_at_end;
  assign bus.COUNTERN_WrapY = bus.COUNTERN_WrapX & y_at_end;

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge COUNTERN_Clk) begin
    if (!COUNTERN_Clr) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      lim_x_q <= '0;
      lim_y_q <= '0;
      lim_c_q <= '0;
      done_q  <= 1'b0;
`ifdef COUNTER_NEST_STRIDE_EN
      stride_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.COUNTERN_Start) begin
            lim_x_q <= bus.COUNTERN_LimX;
            lim_y_q <= bus.COUNTERN_LimY;
            lim_c_q <= bus.COUNTERN_LimC;
`ifdef COUNTER_NEST_STRIDE_EN
            stride_q <= bus.COUNTERN_StrideX;
`endif
            x_q   <= '0;
            y_q   <= '0;
            c_q   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.COUNTERN_En) begin
            if (!x_at_end) begin
              x_q <= x_q + step_ext[WIDTH_X-1:0];
            end else begin
              x_q <= '0;
              if (!y_at_end) begin
                y_q <= y_q + 1'b1;
              end else begin
                y_q <= '0;
                if (!c_at_end) begin
                  c_q <= c_q + 1'b1;
                end else begin
                  c_q    <= '0;
                  state  <= IDLE;
                  done_q <= 1'b1;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_nest.sv
// Scoreboard bench for counter_nest: expected tuples are queued at Start and
// retired as each accepted En step is observed on the DUT outputs.
module tb_counter_nest;

  logic clk = 1'b0;
  logic clr = 1'b0;

  counter_nest_if bus ();

  counter_nest dut (
    .COUNTERN_Clk (clk),
    .COUNTERN_Clr (clr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
    bit wx;
    bit wy;
    bit last;
  } tup_t;

  tup_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic start_sweep(input int lx, input int ly, input int lc, input int st, input bit with_en);
    tup_t e;
    int   s;
`ifdef COUNTER_NEST_STRIDE_EN
    s = (st == 0) ? 1 : st;
    bus.COUNTERN_StrideX = 3'(st);
`else
    s = 1 + 0 * st;
`endif
    for (int c = 0; c <= lc; c++)
      for (int y = 0; y <= ly; y++)
        for (int x = 0; x <= lx; x += s) begin
          e.x = x; e.y = y; e.c = c;
          e.wx   = (x + s > lx);
          e.wy   = e.wx && (y == ly);
          e.last = e.wy && (c == lc);
          sb.push_back(e);
        end
    bus.COUNTERN_LimX  = 8'(lx);
    bus.COUNTERN_LimY  = 8'(ly);
    bus.COUNTERN_LimC  = 4'(lc);
    bus.COUNTERN_Start = 1'b1;
    bus.COUNTERN_En    = with_en;
    @(posedge clk);
    @(negedge clk);
    bus.COUNTERN_Start = 1'b0;
    bus.COUNTERN_En    = 1'b0;
    check("busy_after_start", bus.COUNTERN_Busy, 1);
  endtask

  task automatic run_steps(input bit gap, input bit disturb, input int max_steps);
    tup_t e;
    int   n      = 0;
    int   budget = 1000;
    bit   en     = 1'b1;
    bit   dist_done = 1'b0;
    while (sb.size() > 0 && n < max_steps && budget > 0) begin
      budget--;
      e = sb[0];
      bus.COUNTERN_En = en;
      if (disturb && !dist_done && n == 2) begin
        dist_done = 1'b1;
        bus.COUNTERN_Start = 1'b1;
        bus.COUNTERN_LimX  = 8'd7;
        bus.COUNTERN_LimY  = 8'd7;
        bus.COUNTERN_LimC  = 4'd7;
      end
      #1;
      check("out_x",  bus.COUNTERN_OutX,  e.x);
      check("out_y",  bus.COUNTERN_OutY,  e.y);
      check("out_c",  bus.COUNTERN_OutC,  e.c);
      check("wrap_x", bus.COUNTERN_WrapX, en & e.wx);
      check("wrap_y", bus.COUNTERN_WrapY, en & e.wy);
      check("last",   bus.COUNTERN_Last,  e.last);
      check("busy",   bus.COUNTERN_Busy,  1);
      check("done_early", bus.COUNTERN_Done, 0);
      @(posedge clk);
      @(negedge clk);
      bus.COUNTERN_Start = 1'b0;
      if (en) begin
        void'(sb.pop_front());
        n++;
      end
      if (gap) en = ~en;
    end
    bus.COUNTERN_En = 1'b0;
    if (budget == 0) check("step_budget", 0, 1);
    if (sb.size() == 0) begin
      check("done_pulse", bus.COUNTERN_Done, 1);
      check("busy_end",   bus.COUNTERN_Busy, 0);
      check("x_end",      bus.COUNTERN_OutX, 0);
      check("y_end",      bus.COUNTERN_OutY, 0);
      check("c_end",      bus.COUNTERN_OutC, 0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
    check("done_clear", bus.COUNTERN_Done, 0);
    check("busy_idle",  bus.COUNTERN_Busy, 0);
    check("last_idle",  bus.COUNTERN_Last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.COUNTERN_Start = 1'b1;
    bus.COUNTERN_En    = 1'b1;
    bus.COUNTERN_LimX  = 8'd3;
    bus.COUNTERN_LimY  = 8'd3;
    bus.COUNTERN_LimC  = 4'd3;
`ifdef COUNTER_NEST_STRIDE_EN
    bus.COUNTERN_StrideX = 3'd1;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.COUNTERN_Busy, 0);
    check("rst_done", bus.COUNTERN_Done, 0);
    check("rst_x",    bus.COUNTERN_OutX, 0);
    check("rst_y",    bus.COUNTERN_OutY, 0);
    check("rst_c",    bus.COUNTERN_OutC, 0);
    check("rst_last", bus.COUNTERN_Last, 0);
    bus.COUNTERN_Start = 1'b0;
    bus.COUNTERN_En    = 1'b0;
    clr = 1'b1;
    idle_cycle();

    // Basic sweep, then gapped En with a back-to-back degenerate sweep in the Done cycle.
    start_sweep(2, 1, 1, 1, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();
    start_sweep(2, 1, 1, 1, 1'b0);
    run_steps(1'b1, 1'b0, 1000);
    start_sweep(0, 0, 0, 1, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();

    // Start with En in IDLE, then Start and new limits mid-sweep.
    start_sweep(3, 2, 1, 1, 1'b1);
    run_steps(1'b0, 1'b1, 1000);
    idle_cycle();

    // Reset at tuple (1,1,0) with En high.
    start_sweep(2, 1, 1, 1, 1'b0);
    run_steps(1'b0, 1'b0, 4);
    check("pre_rst_x", bus.COUNTERN_OutX, 1);
    check("pre_rst_y", bus.COUNTERN_OutY, 1);
    clr = 1'b0;
    bus.COUNTERN_En = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy", bus.COUNTERN_Busy, 0);
    check("midrst_done", bus.COUNTERN_Done, 0);
    check("midrst_x",    bus.COUNTERN_OutX, 0);
    check("midrst_y",    bus.COUNTERN_OutY, 0);
    check("midrst_c",    bus.COUNTERN_OutC, 0);
    clr = 1'b1;
    bus.COUNTERN_En = 1'b0;
    sb.delete();
    idle_cycle();
    start_sweep(2, 1, 1, 1, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();

`ifdef COUNTER_NEST_STRIDE_EN
    start_sweep(6, 0, 0, 2, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();
    start_sweep(7, 0, 0, 3, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();
    start_sweep(3, 0, 0, 0, 1'b0);
    run_steps(1'b0, 1'b0, 1000);
    idle_cycle();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_nest.md
# counter_nest

Three-level nested loop counter for the CNN accelerator datapath: generates column (X), row (Y) and channel (C) indices for convolution and pooling sweeps. It replaces chains of single-level enable counters with one block that holds run-time limits, sequences the nesting and reports progress. The block sits between the layer controller, which issues Start and step enables, and the address generators and MAC array, which consume the indices.

## Interface
- WIDTH_X, 8, width of column index and limit
- WIDTH_Y, 8, width of row index and limit
- WIDTH_C, 4, width of channel index and limit
- STRIDE_W, 3, width of X stride input (used only with COUNTER_NEST_STRIDE_EN)

- COUNTERN_Clk  in  1  single clock; all state updates on the rising edge
- COUNTERN_Clr  in  1  reset, synchronous, active-low
- COUNTERN_Start  in  1  begin a sweep; limits sampled this cycle
- COUNTERN_En  in  1  advance one step while running
- COUNTERN_LimX  in  WIDTH_X  last X index, inclusive
- COUNTERN_LimY  in  WIDTH_Y  last Y index, inclusive
- COUNTERN_LimC  in  WIDTH_C  last C index, inclusive
- COUNTERN_StrideX  in  STRIDE_W  X increment (present only with COUNTER_NEST_STRIDE_EN)
- COUNTERN_OutX  out  WIDTH_X  current column index
- COUNTERN_OutY  out  WIDTH_Y  current row index
- COUNTERN_OutC  out  WIDTH_C  current channel index
- COUNTERN_Busy  out  1  sweep in progress
- COUNTERN_Last  out  1  current tuple is the final tuple (combinational from state)
- COUNTERN_WrapX  out  1  this step wraps X (combinational: Busy & En & X at end)
- COUNTERN_WrapY  out  1  this step wraps Y (WrapX & Y == LimY)
- COUNTERN_Done  out  1  one-cycle registered pulse after the final step

## Operation
- States: IDLE, RUN.
- IDLE: Start=1 -> latch LimX/LimY/LimC (and StrideX) into internal registers, X=Y=C=0, go RUN. En ignored in IDLE, including same cycle as Start.
- RUN: Start ignored; latched limits govern; input limit changes have no effect until next sweep.
- RUN, En=1: X innermost, then Y, then C.
  - X not at end -> X += step.
  - X at end -> X=0; if Y<LimY then Y+=1, else Y=0 and C advances likewise.
  - Final tuple (X at end, Y=LimY, C=LimC) -> X=Y=C=0, go IDLE, Done=1 next cycle.
- RUN, En=0: hold all indices.
- "X at end": without stride, X==LimX; with stride, X+step>LimX computed at WIDTH_X+1 bits (no overflow wrap).
- Limits of 0 valid: LimX=LimY=LimC=0 -> one-step sweep.
- Busy=1 exactly while in RUN. Last = RUN & final tuple.
- Indices never exceed latched limits; no modular arithmetic on outputs.

## Timing
- Reset: COUNTERN_Clr=0 at rising edge -> state IDLE, OutX/OutY/OutC=0, Busy=0, Done=0, latched limits=0. Clr overrides Start and En same cycle. Reset mid-sweep aborts with no Done pulse.
- Start sampled at edge k -> Busy=1, indices 0 from edge k+1.
- En sampled at edge k -> new indices visible after edge k.
- Final En at edge k -> Busy=0 and Done=1 after edge k; Done=0 after edge k+1.
- Start at edge k+1, the cycle Done is high, is accepted: back-to-back sweeps, no dead cycle beyond the Done cycle.
- WrapX/WrapY/Last are combinational, valid in the cycle before the edge they describe.
- Total steps per sweep = (nX)(LimY+1)(LimC+1); nX = LimX+1 without stride.

## Configuration
- Macro COUNTER_NEST_STRIDE_EN.
- Defined: COUNTERN_StrideX port present, latched on Start; X step = latched stride, stride 0 treated as 1; nX = floor(LimX/stride)+1.
- Undefined: port absent, X step fixed at 1; STRIDE_W unused.

## Test plan
- Basic sweep: Clr, Start with LimX=2, LimY=1, LimC=1, En held high -> 12 tuples (0,0,0)…(2,1,1) in X-Y-C order, WrapX on steps 3,6,9,12, WrapY on steps 6,12, Done single pulse after 12th En, Busy low same cycle.
- Gapped En: same limits, En toggling 1/0 -> indices hold on En=0, sequence identical, Done after 12th accepted En.
- Degenerate limits: LimX=LimY=LimC=0, Start, one En -> Last=1 before step, Done pulse, outputs remain 0.
- Ignored inputs: Start+En together in IDLE -> indices 0 after edge; Start and changed limits mid-sweep -> no restart, original limits govern.
- Reset mid-sweep: Clr low at tuple (1,1,0) with En=1 -> all outputs 0, Busy=0, no Done; next Start runs full sweep. Back-to-back: Start in Done cycle -> Busy=1 next edge.
- Stride (COUNTER_NEST_STRIDE_EN): LimX=6, StrideX=2, LimY=0, LimC=0 -> X=0,2,4,6 then Done; StrideX=3, LimX=7 -> X=0,3,6 then Done; StrideX=0 behaves as 1.
